// File: rtl/box_overlay_pkg.sv
// rtl/box_overlay_pkg.sv - box entry type, border hit test and pipeline constants
// Optional field blend exists only with BOX_OVERLAY_PIPE_BLEND_EN defined.
package box_overlay_pkg;

  localparam int BX_W     = 11;
  localparam int BY_W     = 10;
  localparam int PIPE_LAT = 2;

  typedef struct packed {
    logic            en;
    logic [BX_W-1:0] sx;
    logic [BY_W-1:0] sy;
    logic [BX_W-1:0] ex;
    logic [BY_W-1:0] ey;
    logic [23:0]     color;
`ifdef BOX_OVERLAY_PIPE_BLEND_EN
    logic            blend;
`endif
  } box_t;

  // One extra bit on every operand so edge + width never wraps at the screen edge.
  function automatic logic border_hit(input box_t b, input logic [BX_W-1:0] x,
                                      input logic [BY_W-1:0] y,
                                      input logic [BX_W:0] hbw, input logic [BY_W:0] vbw);
    logic [BX_W:0] w_x, w_sx, w_ex;
    logic [BY_W:0] w_y, w_sy, w_ey;
    logic          w_valid, w_inside;
    w_x      = {1'b0, x};
    w_sx     = {1'b0, b.sx};
    w_ex     = {1'b0, b.ex};
    w_y      = {1'b0, y};
    w_sy     = {1'b0, b.sy};
    w_ey     = {1'b0, b.ey};
    w_valid  = b.en && (w_sx <= w_ex) && (w_sy <= w_ey);
    w_inside = (w_sx <= w_x) && (w_x <= w_ex) && (w_sy <= w_y) && (w_y <= w_ey);
    return w_valid && w_inside &&
           ((w_x < w_sx + hbw) || (w_x + hbw > w_ex) ||
            (w_y < w_sy + vbw) || (w_y + vbw > w_ey));
  endfunction

endpackage

// File: rtl/box_hit_test.sv
// rtl/box_hit_test.sv - combinational border test for a single box entry
module box_hit_test
  import box_overlay_pkg::*;
#(
  parameter int H_BOX_WIDTH = 2,
  parameter int V_BOX_WIDTH = 2
) (
  input  box_t            i_box,
  input  logic [BX_W-1:0] i_x,
  input  logic [BY_W-1:0] i_y,
  output logic            o_hit
);

  localparam logic [BX_W:0] HBW = (BX_W+1)'(H_BOX_WIDTH);
  localparam logic [BY_W:0] VBW = (BY_W+1)'(V_BOX_WIDTH);

  assign o_hit = border_hit(i_box, i_x, i_y, HBW, VBW);

endmodule

// File: rtl/box_overlay_pipe.sv
// rtl/box_overlay_pipe.sv - two-stage box overlay with frame-atomic box table
// BOX_OVERLAY_PIPE_BLEND_EN adds cfg_blend and per-box 50% colour blending.
module box_overlay_pipe
  import box_overlay_pkg::*;
#(
  parameter int N_BOX       = 4,
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int H_BOX_WIDTH = 2,
  parameter int V_BOX_WIDTH = 2,
  parameter int IDX_W       = (N_BOX > 1) ? $clog2(N_BOX) : 1,
  parameter int X_W         = $clog2(H_ACT),
  parameter int Y_W         = $clog2(V_ACT)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [X_W-1:0]   cfg_sx,
  input  logic [X_W-1:0]   cfg_ex,
  input  logic [Y_W-1:0]   cfg_sy,
  input  logic [Y_W-1:0]   cfg_ey,
  input  logic [23:0]      cfg_color,
`ifdef BOX_OVERLAY_PIPE_BLEND_EN
  input  logic             cfg_blend,
`endif
  input  logic             cfg_commit,
  output logic             commit_pending,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  input  logic [7:0]       i_r,
  input  logic [7:0]       i_g,
  input  logic [7:0]       i_b,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [7:0]       o_r,
  output logic [7:0]       o_g,
  output logic [7:0]       o_b
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_ACT - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACT - 1);

  logic             r_vs_d, r_de_d, r_pend;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  box_t             r_shadow [N_BOX];
  box_t             r_active [N_BOX];
  logic [N_BOX-1:0] r_hit1;
  logic [23:0]      r_pix1, r_out;
  logic [2:0]       r_tim [PIPE_LAT];

  logic             w_fs, w_any;
  box_t             w_wr, w_win;
  logic [N_BOX-1:0] w_hit;
  logic [IDX_W-1:0] w_sel;
  logic [23:0]      w_out;

  assign w_fs = i_vsync & ~r_vs_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_vs_d <= i_vsync;
      r_de_d <= i_de;
      if (w_fs) begin
        r_x <= '0;
        r_y <= '0;
      end else begin
        if (!i_de)
          r_x <= '0;
        else if (r_x != X_MAX)
          r_x <= r_x + 1'b1;
        if (r_de_d && !i_de && r_y != Y_MAX)
          r_y <= r_y + 1'b1;
      end
    end
  end

  always_comb begin
    w_wr       = '0;
    w_wr.en    = cfg_en;
    w_wr.sx    = BX_W'(cfg_sx);
    w_wr.ex    = BX_W'(cfg_ex);
    w_wr.sy    = BY_W'(cfg_sy);
    w_wr.ey    = BY_W'(cfg_ey);
    w_wr.color = cfg_color;
`ifdef BOX_OVERLAY_PIPE_BLEND_EN
    w_wr.blend = cfg_blend;
`endif
  end

  // Non-blocking copy means a write landing on the FS cycle stays in the shadow only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow <= '{default: '0};
      r_active <= '{default: '0};
      r_pend   <= 1'b0;
    end else begin
      if (cfg_we && (int'(cfg_idx) < N_BOX))
        r_shadow[cfg_idx] <= w_wr;
      if (w_fs && (r_pend || cfg_commit)) begin
        r_active <= r_shadow;
        r_pend   <= 1'b0;
      end else if (cfg_commit) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign commit_pending = r_pend;

  for (genvar g = 0; g < N_BOX; g++) begin : g_hit
    box_hit_test #(.H_BOX_WIDTH(H_BOX_WIDTH), .V_BOX_WIDTH(V_BOX_WIDTH)) u_hit (
      .i_box (r_active[g]),
      .i_x   (BX_W'(r_x)),
      .i_y   (BY_W'(r_y)),
      .o_hit (w_hit[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hit1 <= '0;
      r_pix1 <= '0;
      r_out  <= '0;
      r_tim  <= '{default: '0};
    end else begin
      r_hit1   <= i_de ? w_hit : '0;
      r_pix1   <= {i_r, i_g, i_b};
      r_out    <= w_out;
      r_tim[0] <= {i_vsync, i_hsync, i_de};
      for (int k = 1; k < PIPE_LAT; k++)
        r_tim[k] <= r_tim[k-1];
    end
  end

`ifdef BOX_OVERLAY_PIPE_BLEND_EN
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction
`endif

  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = 0; i < N_BOX; i++) begin
      if (r_hit1[i]) begin
        w_any = 1'b1;
        w_sel = IDX_W'(i);
      end
    end
    w_win = r_active[w_sel];
    w_out = r_pix1;
    if (w_any) begin
`ifdef BOX_OVERLAY_PIPE_BLEND_EN
      if (w_win.blend)
        w_out = {avg8(r_pix1[23:16], w_win.color[23:16]),
                 avg8(r_pix1[15:8],  w_win.color[15:8]),
                 avg8(r_pix1[7:0],   w_win.color[7:0])};
      else
        w_out = w_win.color;
`else
      w_out = w_win.color;
`endif
    end
  end

  assign {o_vsync, o_hsync, o_de} = r_tim[PIPE_LAT-1];
  assign {o_r, o_g, o_b}          = r_out;

endmodule

// File: doc/box_overlay_pipe.md
Name: box_overlay_pipe

Overview:
- Registered, pipelined successor to the combinational box-drawing overlay.
- Tracks pixel x/y internally from the video timing signals instead of taking coordinates as inputs.
- Holds a programmable table of N_BOX rectangles. Each entry is written through a config port and committed atomically at frame start.
- Sits in the video output path between the camera/scaler stream and the HDMI encoder; draws detection boxes with per-box colour and priority.

Parameters:
- N_BOX, 4, number of box entries (1..16).
- H_ACT, 1280, active pixels per line; X_W = $clog2(H_ACT).
- V_ACT, 720, active lines per frame; Y_W = $clog2(V_ACT).
- H_BOX_WIDTH, 2, thickness in pixels of the left/right border (>=1).
- V_BOX_WIDTH, 2, thickness in lines of the top/bottom border (>=1).
- IDX_W, (N_BOX>1 ? $clog2(N_BOX) : 1), width of the config index.

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- cfg_we  in  1  write the shadow entry selected by cfg_idx
- cfg_idx  in  IDX_W  entry index; values >= N_BOX are ignored
- cfg_en  in  1  entry enable
- cfg_sx / cfg_ex  in  X_W  inclusive left / right edge
- cfg_sy / cfg_ey  in  Y_W  inclusive top / bottom edge
- cfg_color  in  24  {r,g,b}
- cfg_commit  in  1  request copy of the shadow table to the active table at the next frame start
- commit_pending  out  1  a commit is requested and not yet applied
- i_vsync, i_hsync, i_de  in  1 each  input timing; active-high
- i_r, i_g, i_b  in  8 each  input pixel
- o_vsync, o_hsync, o_de  out  1 each  timing delayed by 2 cycles
- o_r, o_g, o_b  out  8 each  output pixel

Behaviour:
- Reset (asynchronous, rstn low):
  - all outputs are 0.
  - shadow and active tables are cleared (en=0, coordinates 0, colour 0).
  - x=0, y=0, commit_pending=0.
  - the pipeline is flushed.
- Reset asserted mid-frame: outputs drop to 0 immediately. Drawing restarts correctly only after the next vsync rising edge.
- Counters:
  - x: holds 0 while i_de=0. Increments per i_de=1 cycle and saturates at H_ACT-1.
  - y: increments on each i_de falling edge and saturates at V_ACT-1. Clears to 0 on the i_vsync rising edge, which also clears x.
  - The current pixel position is (x,y) sampled with the i_de=1 cycle.
- Frame start (FS) is the i_vsync rising edge, detected with a 1-cycle registered copy of i_vsync.
- Config writes: cfg_we writes shadow[cfg_idx] in one cycle. No handshake; always accepted.
- Commit:
  - cfg_commit sets commit_pending.
  - At FS, if commit_pending or cfg_commit is high, the whole shadow table is copied to the active table and commit_pending clears.
  - cfg_commit coincident with FS commits at that FS.
  - cfg_we coincident with FS: the copy uses the pre-write shadow value; the write lands in the shadow only.
- Box validity: en=1, sx<=ex and sy<=ey. Invalid entries never draw.
- Hit test, per active entry, with (X_W+1)/(Y_W+1)-bit arithmetic so there is no wrap:
  - inside = sx<=x<=ex and sy<=y<=ey.
  - border = inside and (x<sx+H_BOX_WIDTH or x+H_BOX_WIDTH>ex or y<sy+V_BOX_WIDTH or y+V_BOX_WIDTH>ey).
  - Boxes thinner than twice the border width render solid.
- Pipeline:
  - Stage 1 registers the per-box border vector, the input pixel and timing.
  - Stage 2 registers the output.
  - Latency is exactly 2 cycles for pixel and timing alike.
- Priority: the highest-index hitting entry wins. With no hit, the input pixel passes through unchanged.
- During i_de=0 the pixel passes through unmodified.
- The active table changes only at FS, so boxes never tear mid-frame.

Optional Feature:
- Macro: BOX_OVERLAY_PIPE_BLEND_EN
- Defined:
  - adds a per-entry cfg_blend input bit (shadowed/committed like the other fields).
  - Winning entries with blend=1 output per channel (in+color)>>1, truncated, computed in stage 2. Latency is unchanged.
- Undefined: the port is absent and border pixels are replaced by the colour.

Decomposition:
- Package box_overlay_pkg holds:
  - typedef box_t {en, sx, sy, ex, ey, color[, blend]}, parametrised via localparam widths matching H_ACT/V_ACT defaults.
  - function border_hit.
  - the constant PIPE_LAT=2.
- One sub-module, box_hit_test: a combinational border test for a single box, instantiated N_BOX times in a generate loop.

Test Plan:
- Reset then a 1280x720 frame with an empty table -> output equals input delayed 2 cycles, timing delayed 2, commit_pending=0.
- Entry 0 = (100,50)-(199,149), red, committed before vsync -> pixels x in 100..101 or 198..199 (y 50..149), and y in 50..51 or 148..149 (x 100..199), are 0xFF0000. (150,100) passes through.
- Entry 0 red and entry 3 green, overlapping at (120,60) -> green output there (highest index wins).
- cfg_we updating entry 0 to x=300 mid-frame with cfg_commit -> the current frame still draws at x=100, the next frame at x=300; commit_pending is 1 until FS and then 0.
- Degenerate entry sx=500 > ex=400, and entry at (0,0)-(1279,719) -> the first never draws; the second draws the screen edges with no overflow at x=1279.
- BOX_OVERLAY_PIPE_BLEND_EN defined, blend=1, colour 0xFF0000 over input 0x204060 -> output 0x8F2030.
